// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions from MEM, waits for load data,
// extracts/extends it and presents a one-cycle registered register-file write.
module wb_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic              mem_wreg,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_is_load,
   input  logic [2:0]        mem_load_type,
   input  logic [1:0]        mem_addr_lo,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              flush,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              load_pending
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [2:0] LT_LB  = 3'd0;
   localparam logic [2:0] LT_LBU = 3'd1;
   localparam logic [2:0] LT_LH  = 3'd2;
   localparam logic [2:0] LT_LHU = 3'd3;

   state_t            state;
   logic              cap_wreg;
   logic [ADDR_W-1:0] cap_waddr;
   logic              cap_is_load;
   logic [2:0]        cap_load_type;
   logic [1:0]        cap_addr_lo;

   logic              accept;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_data;

   assign mem_ready = (state != WAIT);
   assign accept    = mem_valid & mem_ready & ~flush;

   // Load extraction from the captured type/offset; types 5-7 fall through to LW.
   always_comb begin
      ld_byte = dmem_rdata[8*cap_addr_lo +: 8];
      ld_half = cap_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      ld_data = dmem_rdata;
      case (cap_load_type)
         LT_LB:   ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         LT_LBU:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
         LT_LH:   ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
         LT_LHU:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= EMPTY;
         we            <= 1'b0;
         waddr         <= '0;
         wdata         <= '0;
         load_pending  <= 1'b0;
         cap_wreg      <= 1'b0;
         cap_waddr     <= '0;
         cap_is_load   <= 1'b0;
         cap_load_type <= '0;
         cap_addr_lo   <= '0;
      end else if (flush) begin
         // The write already on the port this cycle is unaffected; only what follows is dropped.
         state        <= EMPTY;
         we           <= 1'b0;
         load_pending <= 1'b0;
      end else if (accept) begin
         cap_wreg      <= mem_wreg;
         cap_waddr     <= mem_waddr;
         cap_is_load   <= mem_is_load;
         cap_load_type <= mem_load_type;
         cap_addr_lo   <= mem_addr_lo;
         if (mem_is_load) begin
            state        <= WAIT;
            we           <= 1'b0;
            load_pending <= 1'b1;
         end else begin
            state        <= COMMIT;
            we           <= mem_wreg & (mem_waddr != '0);
            waddr        <= mem_waddr;
            wdata        <= mem_wdata;
            load_pending <= 1'b0;
         end
      end else if (state == WAIT) begin
         we <= 1'b0;
         if (dmem_rvalid && cap_is_load) begin
            state        <= COMMIT;
            we           <= cap_wreg & (cap_waddr != '0);
            waddr        <= cap_waddr;
            wdata        <= ld_data;
            load_pending <= 1'b0;
         end
      end else begin
         state <= EMPTY;
         we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU ops, loads, back-to-back, flush, reset.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_wreg;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_is_load;
   logic [2:0]  mem_load_type;
   logic [1:0]  mem_addr_lo;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        flush;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        load_pending;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wreg(mem_wreg),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
      .mem_load_type(mem_load_type), .mem_addr_lo(mem_addr_lo),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .flush(flush),
      .we(we), .waddr(waddr), .wdata(wdata), .load_pending(load_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input logic [4:0] a, input logic [31:0] d);
      mem_valid = 1'b1; mem_is_load = 1'b0; mem_wreg = 1'b1;
      mem_waddr = a; mem_wdata = d;
   endtask

   // Accept a load, return data 'dly' cycles after accept, check the resulting write.
   task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] lo,
                          input logic [31:0] rd, input logic [4:0] a,
                          input int unsigned dly, input logic [31:0] exp);
      mem_valid = 1'b1; mem_is_load = 1'b1; mem_wreg = 1'b1; mem_waddr = a;
      mem_wdata = 32'h0; mem_load_type = lt; mem_addr_lo = lo;
      tick();
      mem_valid = 1'b0;
      for (int i = 0; i < int'(dly) - 1; i++) begin
         check({tag, "_pend"}, {31'b0, load_pending}, 32'd1);
         check({tag, "_ready"}, {31'b0, mem_ready}, 32'd0);
         check({tag, "_we_wait"}, {31'b0, we}, 32'd0);
         tick();
      end
      dmem_rvalid = 1'b1; dmem_rdata = rd;
      tick();
      dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      check({tag, "_we"}, {31'b0, we}, 32'd1);
      check({tag, "_waddr"}, {27'b0, waddr}, {27'b0, a});
      check({tag, "_wdata"}, wdata, exp);
      check({tag, "_pend_clr"}, {31'b0, load_pending}, 32'd0);
      tick();
      check({tag, "_we_off"}, {31'b0, we}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; mem_valid = 1'b0; mem_wreg = 1'b0; mem_waddr = '0; mem_wdata = '0;
      mem_is_load = 1'b0; mem_load_type = '0; mem_addr_lo = '0;
      dmem_rvalid = 1'b0; dmem_rdata = '0; flush = 1'b0;
      #12;
      check("rst_we", {31'b0, we}, 32'd0);
      check("rst_waddr", {27'b0, waddr}, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_pend", {31'b0, load_pending}, 32'd0);
      check("rst_ready", {31'b0, mem_ready}, 32'd1);
      rst = 1'b0;
      tick();

      // ALU op, 1-cycle latency, single-cycle write, outputs hold afterwards
      alu_op(5'd5, 32'h12345678);
      tick();
      mem_valid = 1'b0;
      check("alu_we", {31'b0, we}, 32'd1);
      check("alu_waddr", {27'b0, waddr}, 32'd5);
      check("alu_wdata", wdata, 32'h12345678);
      tick();
      check("alu_we_off", {31'b0, we}, 32'd0);
      check("alu_hold_waddr", {27'b0, waddr}, 32'd5);
      check("alu_hold_wdata", wdata, 32'h12345678);

      // Loads
      do_load("lb",   3'd0, 2'd3, 32'h80FF7F01, 5'd9,  3, 32'hFFFFFF80);
      do_load("lbu",  3'd1, 2'd3, 32'h80FF7F01, 5'd10, 3, 32'h00000080);
      do_load("lb1",  3'd0, 2'd1, 32'h80FF7F01, 5'd10, 1, 32'h0000007F);
      do_load("lh",   3'd2, 2'd2, 32'h8001FFFE, 5'd11, 2, 32'hFFFF8001);
      do_load("lhu",  3'd3, 2'd2, 32'h8001FFFE, 5'd12, 1, 32'h00008001);
      do_load("lh0",  3'd2, 2'd1, 32'h8001FFFE, 5'd12, 1, 32'hFFFFFFFE);
      do_load("lw",   3'd4, 2'd0, 32'h8001FFFE, 5'd13, 2, 32'h8001FFFE);
      do_load("lt6",  3'd6, 2'd3, 32'h8001FFFE, 5'd14, 1, 32'h8001FFFE);

      // Back-to-back ALU ops to r1, r2, r3
      alu_op(5'd1, 32'h11111111);
      tick();
      check("b2b_we1", {31'b0, we}, 32'd1);
      check("b2b_a1", {27'b0, waddr}, 32'd1);
      check("b2b_ready1", {31'b0, mem_ready}, 32'd1);
      alu_op(5'd2, 32'h22222222);
      tick();
      check("b2b_we2", {31'b0, we}, 32'd1);
      check("b2b_a2", {27'b0, waddr}, 32'd2);
      check("b2b_d2", wdata, 32'h22222222);
      check("b2b_ready2", {31'b0, mem_ready}, 32'd1);
      alu_op(5'd3, 32'h33333333);
      tick();
      mem_valid = 1'b0;
      check("b2b_we3", {31'b0, we}, 32'd1);
      check("b2b_a3", {27'b0, waddr}, 32'd3);
      check("b2b_d3", wdata, 32'h33333333);
      tick();
      check("b2b_we_off", {31'b0, we}, 32'd0);

      // Flush in WAIT together with rvalid: nothing written
      mem_valid = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd20; mem_load_type = 3'd4;
      tick();
      mem_valid = 1'b0;
      check("fw_pend", {31'b0, load_pending}, 32'd1);
      flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
      tick();
      flush = 1'b0; dmem_rvalid = 1'b0;
      check("fw_we", {31'b0, we}, 32'd0);
      check("fw_pend_clr", {31'b0, load_pending}, 32'd0);
      check("fw_ready", {31'b0, mem_ready}, 32'd1);
      check("fw_waddr_hold", {27'b0, waddr}, 32'd3);
      tick();
      check("fw_we_later", {31'b0, we}, 32'd0);

      // Flush in COMMIT: current write stands; concurrent mem_valid is not accepted
      alu_op(5'd7, 32'h77777777);
      tick();
      check("fc_we", {31'b0, we}, 32'd1);
      check("fc_waddr", {27'b0, waddr}, 32'd7);
      alu_op(5'd8, 32'h88888888);
      flush = 1'b1;
      tick();
      flush = 1'b0; mem_valid = 1'b0;
      check("fc_we_off", {31'b0, we}, 32'd0);
      check("fc_waddr_hold", {27'b0, waddr}, 32'd7);

      // Write to r0 never asserts we
      alu_op(5'd0, 32'hDEADBEEF);
      tick();
      mem_valid = 1'b0;
      check("r0_we", {31'b0, we}, 32'd0);
      tick();
      check("r0_we_after", {31'b0, we}, 32'd0);

      // Asynchronous reset mid-WAIT
      mem_valid = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd21; mem_load_type = 3'd4;
      tick();
      mem_valid = 1'b0;
      check("ar_pend", {31'b0, load_pending}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_we", {31'b0, we}, 32'd0);
      check("ar_waddr", {27'b0, waddr}, 32'd0);
      check("ar_wdata", wdata, 32'd0);
      check("ar_pend_clr", {31'b0, load_pending}, 32'd0);
      check("ar_ready", {31'b0, mem_ready}, 32'd1);
      #1 rst = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5A5A5A5A;
      tick();
      dmem_rvalid = 1'b0;
      check("ar_rv_we", {31'b0, we}, 32'd0);
      check("ar_rv_wdata", wdata, 32'd0);
      tick();
      check("ar_rv_we2", {31'b0, we}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage that drives the write port of the register file: `we`, `waddr` and `wdata`.
- Accepts one retiring instruction per handshake from the MEM stage.
- For loads, waits for the data-memory response, then byte/halfword-selects and sign/zero-extends it.
- Presents a single-cycle registered write to the register file, with flush support.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported; the load extraction is written for 32.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  wb_stage can accept this cycle.
- mem_wreg  in  1  instruction writes a register.
- mem_waddr  in  ADDR_W  destination register.
- mem_wdata  in  DATA_W  ALU/result data, used for non-loads.
- mem_is_load  in  1  instruction is a load.
- mem_load_type  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW; 5-7 are treated as LW.
- mem_addr_lo  in  2  low bits of the load address.
- dmem_rvalid  in  1  load data valid, single-cycle pulse.
- dmem_rdata  in  DATA_W  load data word, little-endian.
- flush  in  1  discard any uncommitted instruction.
- we  out  1  register-file write enable, registered.
- waddr  out  ADDR_W  register-file write address, registered.
- wdata  out  DATA_W  register-file write data, registered.
- load_pending  out  1  high while in WAIT.

Behaviour:
- Reset (asynchronous): state=EMPTY; we=0, waddr=0, wdata=0, load_pending=0; all captured fields cleared.
- States:
  - EMPTY: nothing held.
  - WAIT: load accepted, data not yet returned.
  - COMMIT: `we`/`waddr`/`wdata` are presenting a write this cycle.
- Acceptance:
  - mem_ready = (state != WAIT).
  - Accept = mem_valid & mem_ready & ~flush.
  - Accept captures wreg, waddr, is_load, load_type, addr_lo, and wdata (non-load).
- Non-load accept in cycle T:
  - Next state COMMIT.
  - In cycle T+1: we = mem_wreg & (mem_waddr != 0), waddr = mem_waddr, wdata = mem_wdata.
  - Latency is 1 cycle.
- Load accept in cycle T: next state WAIT; load_pending=1 from T+1.
- WAIT:
  - dmem_rvalid=0: stay in WAIT.
  - dmem_rvalid=1 in cycle R: extract and extend the data. In cycle R+1 present a write (we = captured wreg & waddr!=0), with state COMMIT.
  - dmem_rvalid is ignored in any state other than WAIT.
- Load extraction:
  - LB/LBU: byte = rdata[8*addr_lo +: 8]; LB sign-extends, LBU zero-extends.
  - LH/LHU: half = addr_lo[1] ? rdata[31:16] : rdata[15:0]; addr_lo[0] is ignored. LH sign-extends, LHU zero-extends.
  - LW: the full word; addr_lo is ignored.
- COMMIT:
  - Lasts exactly one cycle. we must never be high for two cycles from one instruction.
  - A new accept in the COMMIT cycle is legal (back-to-back); the next state follows the new instruction.
  - With no accept, the next state is EMPTY and we=0.
- Output hold: when no write is presented, we=0 and waddr/wdata hold their last values.
- Flush:
  - Next state EMPTY; a pending load is dropped, and its dmem_rvalid is ignored even in the same cycle (flush wins over rvalid).
  - Flush does not cancel a write already being presented in the current COMMIT cycle.
  - Flush in the same cycle as mem_valid means nothing is accepted.
- waddr==0 commits: the state sequence is unchanged but we stays 0.
- Reset mid-WAIT: the load is dropped immediately; a later dmem_rvalid is ignored.

Test Plan:
- ALU op: mem_valid=1, wreg=1, waddr=5, wdata=0x12345678 at T -> at T+1 we=1, waddr=5, wdata=0x12345678; at T+2 we=0.
- LB: addr_lo=3, dmem_rdata=0x80FF7F01, rvalid 3 cycles after accept -> mem_ready=0 and load_pending=1 while waiting; the cycle after rvalid we=1, wdata=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LH/LHU/LW: rdata=0x8001FFFE, addr_lo=2 -> LH 0xFFFF8001, LHU 0x00008001; addr_lo=0 LW -> 0x8001FFFE; load_type=6 -> same as LW.
- Back-to-back: three ALU ops on consecutive cycles to r1, r2, r3 -> we high for 3 consecutive cycles with matching addr/data; mem_ready constantly 1.
- Flush: flush asserted in WAIT together with rvalid -> no write, state EMPTY, mem_ready=1 next cycle. Separately, flush in the COMMIT cycle -> that write still occurs.
- waddr=0 ALU op with wdata=0xDEADBEEF -> we stays 0. Async rst mid-WAIT -> outputs zero immediately; a later rvalid produces no write.
